// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one external 1Mx16 SRAM between the SLC-3 CPU (port 0) and a
// DMA/program-loader (port 1). The winner's command is latched in IDLE and the
// active-low chip strobes are sequenced SETUP -> ACCESS x WAIT_CYCLES -> DONE.
// All strobes, acks, read data and busy are registered from the current state,
// so the pins follow the FSM state by one cycle. Read data is captured at the
// end of the last OE-low pin cycle and appears together with the ack.
// Optional feature macro: SRAM_ARB_ROUND_ROBIN_EN (round-robin on ties;
// default build uses fixed priority with the CPU winning ties).

module sram_port_arbiter #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic [15:0] cpu_rdata,
   output logic        cpu_ack,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [15:0] dma_addr,
   input  logic [15:0] dma_wdata,
   output logic [15:0] dma_rdata,
   output logic        dma_ack,
   output logic        CE,
   output logic        UB,
   output logic        LB,
   output logic        OE,
   output logic        WE,
   output logic [19:0] ADDR,
   output logic [15:0] Data_to_SRAM,
   input  logic [15:0] Data_from_SRAM,
   output logic        sram_drive,
   output logic        busy
);

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          grant_q, grant_d;
   logic          we_q, we_d;
   logic [15:0]   addr_q, addr_d;
   logic [15:0]   wdata_q, wdata_d;
   logic [15:0]   cpu_rdata_q, cpu_rdata_d;
   logic [15:0]   dma_rdata_q, dma_rdata_d;
   logic          ce_q, ce_d;
   logic          oe_q, oe_d;
   logic          wen_q, wen_d;
   logic          drive_q, drive_d;
   logic          cpu_ack_q, cpu_ack_d;
   logic          dma_ack_q, dma_ack_d;
   logic          busy_q, busy_d;
   logic          pick_dma;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic          last_q, last_d;
`endif

   // Next-state, command latch, arbitration and next pin values from the current state
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      grant_d     = grant_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dma_rdata_d = dma_rdata_q;
      ce_d        = 1'b1;
      oe_d        = 1'b1;
      wen_d       = 1'b1;
      drive_d     = 1'b0;
      cpu_ack_d   = 1'b0;
      dma_ack_d   = 1'b0;
      busy_d      = (state_q != IDLE);
      pick_dma    = 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_d      = last_q;
      if (cpu_req && dma_req) begin
         pick_dma = ~last_q;
      end else begin
         pick_dma = dma_req;
      end
`else
      pick_dma = ~cpu_req;
`endif
      case (state_q)
         IDLE: begin
            if (cpu_req || dma_req) begin
               grant_d = pick_dma;
               we_d    = pick_dma ? dma_we    : cpu_we;
               addr_d  = pick_dma ? dma_addr  : cpu_addr;
               wdata_d = pick_dma ? dma_wdata : cpu_wdata;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
               last_d  = pick_dma;
`endif
               state_d = SETUP;
            end
         end
         SETUP: begin
            ce_d    = 1'b0;
            cnt_d   = CNT_LOAD;
            state_d = ACCESS;
         end
         ACCESS: begin
            ce_d = 1'b0;
            if (we_q) begin
               wen_d   = 1'b0;
               drive_d = 1'b1;
            end else begin
               oe_d = 1'b0;
            end
            if (cnt_q == '0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE: begin
            cpu_ack_d = ~grant_q;
            dma_ack_d = grant_q;
            if (!we_q) begin
               if (grant_q) begin
                  dma_rdata_d = Data_from_SRAM;
               end else begin
                  cpu_rdata_d = Data_from_SRAM;
               end
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, latched command and registered pin outputs; reset aborts any access silently
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         grant_q     <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= 16'h0000;
         wdata_q     <= 16'h0000;
         cpu_rdata_q <= 16'h0000;
         dma_rdata_q <= 16'h0000;
         ce_q        <= 1'b1;
         oe_q        <= 1'b1;
         wen_q       <= 1'b1;
         drive_q     <= 1'b0;
         cpu_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
         busy_q      <= 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
         last_q      <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         grant_q     <= grant_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
         ce_q        <= ce_d;
         oe_q        <= oe_d;
         wen_q       <= wen_d;
         drive_q     <= drive_d;
         cpu_ack_q   <= cpu_ack_d;
         dma_ack_q   <= dma_ack_d;
         busy_q      <= busy_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
         last_q      <= last_d;
`endif
      end
   end

   assign CE           = ce_q;
   assign UB           = ce_q;
   assign LB           = ce_q;
   assign OE           = oe_q;
   assign WE           = wen_q;
   assign sram_drive   = drive_q;
   assign ADDR         = {4'h0, addr_q};
   assign Data_to_SRAM = wdata_q;
   assign cpu_rdata    = cpu_rdata_q;
   assign dma_rdata    = dma_rdata_q;
   assign cpu_ack      = cpu_ack_q;
   assign dma_ack      = dma_ack_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
// Directed bench for sram_port_arbiter with WAIT_CYCLES=2 and a 64K-word SRAM
// model. Expected values are hand-derived; the grant order follows
// SRAM_ARB_ROUND_ROBIN_EN when it is defined.

module tb_sram_port_arbiter;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic [15:0] cpu_rdata, dma_rdata;
   logic        cpu_ack, dma_ack;
   logic        CE, UB, LB, OE, WE, sram_drive, busy;
   logic [19:0] ADDR;
   logic [15:0] Data_to_SRAM, Data_from_SRAM;

   logic [15:0] mem [0:65535];
   logic        pre_we;
   logic [15:0] pre_addr, pre_data;

   int total = 0;
   int bad   = 0;

   sram_port_arbiter #(.WAIT_CYCLES(2)) dut (
      .Clk(Clk), .Reset(Reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata), .dma_ack(dma_ack),
      .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
      .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
      .sram_drive(sram_drive), .busy(busy)
   );

   always #5 Clk = ~Clk;

   // SRAM model: preload port for the bench, otherwise writes while CE and WE are low
   always @(posedge Clk) begin
      if (pre_we) begin
         mem[pre_addr] <= pre_data;
      end else if (!CE && !WE) begin
         mem[ADDR[15:0]] <= Data_to_SRAM;
      end
   end

   assign Data_from_SRAM = mem[ADDR[15:0]];

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic port, input logic we, input logic [15:0] addr,
                                input logic [15:0] wdata);
      if (port) begin
         dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1;
      end else begin
         cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
      end
   endtask

   // Waits for either ack, at most limit cycles; cycles counts edges consumed
   task automatic waitAck(input int limit, output int cycles, output logic ok);
      cycles = 0;
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         tick();
         cycles++;
         if (cpu_ack || dma_ack) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // One full access from an idle arbiter with pin checks on every cycle
   task automatic runAccess(input string tag, input logic port, input logic we,
                            input logic [15:0] addr, input logic [15:0] wdata,
                            input logic [15:0] exp_rdata);
      applyStimulus(port, we, addr, wdata);
      tick();
      checkOutput({tag, ".k0busy"}, busy, 0);
      checkOutput({tag, ".addr"}, ADDR, {4'h0, addr});
      tick();
      checkOutput({tag, ".setup"}, {CE, UB, LB, OE, WE, sram_drive}, 6'b000110);
      checkOutput({tag, ".busy"}, busy, 1);
      for (int k = 0; k < 2; k++) begin
         tick();
         checkOutput({tag, ".access"}, {CE, UB, LB, OE, WE, sram_drive},
                     we ? 6'b000101 : 6'b000010);
         checkOutput({tag, ".noack"}, {cpu_ack, dma_ack}, 2'b00);
         if (we) checkOutput({tag, ".wdata"}, Data_to_SRAM, wdata);
      end
      tick();
      checkOutput({tag, ".done"}, {CE, UB, LB, OE, WE, sram_drive}, 6'b111110);
      checkOutput({tag, ".ack"}, {cpu_ack, dma_ack}, port ? 2'b01 : 2'b10);
      if (!we) checkOutput({tag, ".rdata"}, port ? dma_rdata : cpu_rdata, exp_rdata);
      cpu_req = 1'b0;
      dma_req = 1'b0;
      tick();
      checkOutput({tag, ".ackpulse"}, {cpu_ack, dma_ack}, 2'b00);
      checkOutput({tag, ".idle"}, busy, 0);
   endtask

   initial begin
      int          cyc;
      logic        ok;
      logic [1:0]  exp_ack;
      logic        ack_seen;

      Reset = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0; dma_wdata = 16'h0;
      pre_we = 1'b1; pre_addr = 16'h0042; pre_data = 16'hBEEF;
      tick();
      pre_addr = 16'h0100; pre_data = 16'hCAFE;
      tick();
      pre_we = 1'b0;
      checkOutput("rst.strobes", {CE, UB, LB, OE, WE, sram_drive}, 6'b111110);
      checkOutput("rst.busy", busy, 0);
      checkOutput("rst.acks", {cpu_ack, dma_ack}, 2'b00);
      checkOutput("rst.addr", ADDR, 20'h0);
      checkOutput("rst.rdata", {cpu_rdata, dma_rdata}, 32'h0);
      Reset = 1'b0;
      tick();

      $display("[TB] CPU read of 0x0042");
      runAccess("cpuread", 1'b0, 1'b0, 16'h0042, 16'h0000, 16'hBEEF);

      $display("[TB] DMA write of 0x1234 to 0x3000");
      runAccess("dmawrite", 1'b1, 1'b1, 16'h3000, 16'h1234, 16'h0000);
      checkOutput("dmawrite.mem", mem[16'h3000], 16'h1234);

      $display("[TB] both ports requesting for four accesses");
      applyStimulus(1'b0, 1'b0, 16'h0042, 16'h0000);
      applyStimulus(1'b1, 1'b0, 16'h3000, 16'h0000);
      for (int n = 0; n < 4; n++) begin
         waitAck(20, cyc, ok);
         checkOutput("both.timeout", ok, 1);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
         exp_ack = (n % 2 == 0) ? 2'b10 : 2'b01;
`else
         exp_ack = 2'b10;
`endif
         checkOutput("both.grant", {cpu_ack, dma_ack}, exp_ack);
         if (n == 3) begin
            cpu_req = 1'b0;
            dma_req = 1'b0;
         end
      end
      tick();
      tick();
      checkOutput("both.stopped", busy, 0);

      $display("[TB] CPU request held across ack");
      applyStimulus(1'b0, 1'b0, 16'h0042, 16'h0000);
      waitAck(20, cyc, ok);
      checkOutput("held.timeout1", ok, 1);
      checkOutput("held.latency", cyc, 5);
      tick();
      checkOutput("held.gap", {CE, cpu_ack}, 2'b10);
      tick();
      checkOutput("held.setup2", {CE, OE, WE}, 3'b011);
      waitAck(20, cyc, ok);
      checkOutput("held.timeout2", ok, 1);
      checkOutput("held.spacing", cyc, 3);
      checkOutput("held.rdata", cpu_rdata, 16'hBEEF);
      cpu_req = 1'b0;
      tick();
      tick();
      checkOutput("held.stopped", busy, 0);

      $display("[TB] CPU address changed mid-access");
      applyStimulus(1'b0, 1'b0, 16'h0100, 16'h0000);
      tick();
      tick();
      cpu_addr = 16'h0200;
      tick();
      checkOutput("addrchg.access", ADDR, 20'h00100);
      tick();
      tick();
      checkOutput("addrchg.ack", cpu_ack, 1);
      checkOutput("addrchg.rdata", cpu_rdata, 16'hCAFE);
      cpu_req = 1'b0;
      tick();
      checkOutput("addrchg.hold", ADDR, 20'h00100);

      $display("[TB] reset in second ACCESS cycle of a write");
      applyStimulus(1'b1, 1'b1, 16'h3100, 16'h5A5A);
      tick();
      tick();
      tick();
      tick();
      checkOutput("rstmid.we", {WE, sram_drive}, 2'b01);
      Reset = 1'b1;
      dma_req = 1'b0;
      tick();
      checkOutput("rstmid.strobes", {CE, UB, LB, OE, WE, sram_drive}, 6'b111110);
      checkOutput("rstmid.busy", busy, 0);
      checkOutput("rstmid.addr", {ADDR, Data_to_SRAM}, 36'h0);
      checkOutput("rstmid.rdata", {cpu_rdata, dma_rdata}, 32'h0);
      Reset = 1'b0;
      ack_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         ack_seen = ack_seen | cpu_ack | dma_ack;
      end
      checkOutput("rstmid.noack", ack_seen, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
